// File: rtl/fir_out_capture.sv
// Triggered capture of the FIR output stream into a first-word-fall-through FIFO
// that a host drains over a valid/ready port, concurrently with capture if desired.
module fir_out_capture #(
  parameter int DW    = 22,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] filt_in,
  input  logic          samp_en,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig_mode,
  input  logic [DW-1:0] trig_level,
  input  logic [AW:0]   cap_len,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   fill_level
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] level_q, level_d;
  logic          done_q, done_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic          push;
  logic          pop;
  logic          level_hit;
  logic [AW:0]   len_sel;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    mode_d   = mode_q;
    level_d  = level_q;
    done_d   = done_q;
    mem_d    = mem_q;
    push     = 1'b0;
    pop      = rd_ready && (fill_q != '0);

    // A zero or oversize length means "fill the whole FIFO".
    len_sel   = ((cap_len == '0) || (cap_len > FULL)) ? FULL : cap_len;
    level_hit = $signed(filt_in) >= $signed(level_q);

    case (state_q)
      IDLE: begin
        if (arm) begin
          len_d   = len_sel;
          mode_d  = trig_mode;
          level_d = trig_level;
          done_d  = 1'b0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (samp_en && (!mode_q || level_hit)) begin
          push    = 1'b1;
          cnt_d   = ONE_C;
          state_d = (len_q == ONE_C) ? DRAIN : CAPTURE;
        end
      end
      CAPTURE: begin
        if (samp_en) begin
          push  = 1'b1;
          cnt_d = cnt_q + ONE_C;
          if ((cnt_q + ONE_C) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fill_d = fill_q + (push ? ONE_C : '0) - (pop ? ONE_C : '0);

    if ((state_q == DRAIN) && (fill_d == '0)) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = filt_in;
      wr_ptr_d        = wr_ptr_q + ONE_P;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE_P;
    end

    // Abort overrides everything, including an arm or a pop in the same cycle.
    if (abort) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      cnt_d    = '0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      level_q  <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      level_q  <= level_d;
      done_q   <= done_d;
      mem_q    <= mem_d;
    end
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign rd_valid   = (fill_q != '0);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign fill_level = fill_q;

endmodule
